pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding/stall controller for the 5-stage RV32I pipeline (IF,ID,EX,MEM,WB).
//  Centralises load-use stall, EX operand forwarding, branch flush for a configurable resolve stage,
//  and multicycle-EX hold. Adds perf counters. The pipeline top instantiates one; stages consume its enables/flushes.
// PARAMETERS
//  REG_AW        5   register address width
//  BRANCH_STAGE  1   stage resolving branches: 1=ID, 2=EX, 3=MEM
//  FWD_EN        1   1=forwarding on; 0=stall on every RAW, fwd_* held 2'b00
//  CNT_W         32  perf counter width
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  id_rs1/id_rs2  in   REG_AW ID source regs;  id_use_rs1/id_use_rs2 in 1: source actually read
//  ex_rs1/ex_rs2  in   REG_AW EX source regs (forwarding compare)
//  ex_rd,mem_rd,wb_rd                 in REG_AW  destination regs per stage
//  ex_reg_write,mem_reg_write,wb_reg_write in 1  stage writes rd
//  ex_mem_read    in   1      EX instruction is a load
//  branch_taken   in   1      taken branch/jump resolved in BRANCH_STAGE this cycle
//  ex_mc_start    in   1      EX starts a multicycle op;  ex_mc_done in 1: op result valid this cycle
//  wb_valid       in   1      valid instruction retires;  cnt_clear in 1: zero all counters
//  pc_enable,if_id_enable,id_ex_enable out 1    stage register load enables
//  if_flush,id_flush,ex_flush out 1   bubble into IF/ID, ID/EX, EX/MEM
//  fwd_a,fwd_b    out  2      00=regfile 01=MEM/WB 10=EX/MEM
//  cycle_cnt,instret_cnt,stall_cnt,flush_cnt out CNT_W
//  mc_busy        out  1      FSM in MC_WAIT
// BEHAVIOUR
//  Reset (reset=1 at edge): state=RUN, counters=0. While reset high, combinational outputs forced:
//   enables=0, all flushes=1, fwd_*=00, mc_busy=0.
//  Forwarding (comb, FWD_EN=1): fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1;
//   else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1; else 00. Same for fwd_b/ex_rs2. EX/MEM wins ties.
//  RAW hit(r,s) = s_reg_write && s_rd!=0 && s_rd==r && use. Regfile is write-first; WB never stalls.
//  Load-use stall: FWD_EN=1: hit vs EX && ex_mem_read. FWD_EN=0: any hit vs EX or MEM.
//   stall => pc_enable=0, if_id_enable=0, id_flush=1 (bubble), id_ex_enable=1.
//  Branch (branch_taken=1): flush all stages younger than BRANCH_STAGE:
//   1 -> if_flush; 2 -> if_flush,id_flush; 3 -> if_flush,id_flush,ex_flush. pc_enable=1 (redirect).
//   Branch overrides load-use stall in same cycle. flush_cnt += 1.
//  FSM RUN/MC_WAIT:
//   RUN:  ex_mc_start && !ex_mc_done -> MC_WAIT; start&&done same cycle -> stay RUN, no hold.
//   MC_WAIT: pc_enable=if_id_enable=id_ex_enable=0, ex_flush=1 (bubble to MEM), mc_busy=1.
//     ex_mc_done -> RUN next edge (hold released in done cycle).
//     branch_taken with BRANCH_STAGE=3 (older MEM instr) -> abort: RUN, branch flush set applies.
//     BRANCH_STAGE<3 cannot resolve during MC_WAIT; branch_taken ignored.
//  Counters: cycle_cnt +1 every non-reset cycle; instret_cnt +1 on wb_valid; stall_cnt +1 when
//   pc_enable=0 (load-use or MC_WAIT); wrap modulo 2^CNT_W. cnt_clear: all 0 next edge, overrides increment.
//  Latency: all control outputs combinational same cycle; only FSM and counters registered.
// TESTING
//  add x1 in MEM, EX reads x1 as rs1 -> fwd_a=10; same in WB only -> fwd_a=01; rd=x0 -> fwd_a=00.
//  lw x5 in EX, ID add uses x5 -> 1 cycle pc_enable=0,id_flush=1; stall_cnt 0->1; next cycle no stall.
//  BRANCH_STAGE=3, branch_taken -> if/id/ex_flush=1, flush_cnt+1; same cycle load-use -> pc_enable=1.
//  ex_mc_start, ex_mc_done 4 cycles later -> mc_busy 4 cycles, stall_cnt +4, RUN after done.
//  FWD_EN=0, RAW vs MEM stage -> stall until producer in WB; fwd_*=00 throughout.
//  Reset mid-MC_WAIT -> RUN, counters 0; CNT_W=4, 16 wb_valid -> instret_cnt wraps to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline stage status in, stage enables/flushes/forward selects/perf counters out.
// The pipeline drives through the master modport; the controller sits on the slave side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              id_use_rs1, id_use_rs2;
  logic              ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read;
  logic              branch_taken, ex_mc_start, ex_mc_done, wb_valid, cnt_clear;
  logic              pc_enable, if_id_enable, id_ex_enable;
  logic              if_flush, id_flush, ex_flush;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  cycle_cnt, instret_cnt, stall_cnt, flush_cnt;
  logic              mc_busy;

  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, id_use_rs1, id_use_rs2,
           ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read,
           branch_taken, ex_mc_start, ex_mc_done, wb_valid, cnt_clear,
    input  pc_enable, if_id_enable, id_ex_enable, if_flush, id_flush, ex_flush,
           fwd_a, fwd_b, cycle_cnt, instret_cnt, stall_cnt, flush_cnt, mc_busy
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, id_use_rs1, id_use_rs2,
           ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read,
           branch_taken, ex_mc_start, ex_mc_done, wb_valid, cnt_clear,
    output pc_enable, if_id_enable, id_ex_enable, if_flush, id_flush, ex_flush,
           fwd_a, fwd_b, cycle_cnt, instret_cnt, stall_cnt, flush_cnt, mc_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage RV32I hazard controller: load-use stall, EX forwarding, branch flush, multicycle-EX hold, perf counters.
// All control outputs are combinational in the same cycle; only the RUN/MC_WAIT state and counters are registered.
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int BRANCH_STAGE = 1,
  parameter int FWD_EN       = 1,
  parameter int CNT_W        = 32
) (
  input logic                 clock,
  input logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MC_WAIT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cycle_q, instret_q, stall_q, flush_q;

  logic hit_ex, hit_mem, load_use, mc_pend, br, hold;
  logic pc_en, if_id_en, id_ex_en, if_fl, id_fl, ex_fl;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic raw_hit(logic we, logic [REG_AW-1:0] rd, logic [REG_AW-1:0] rs, logic use_rs);
    return we && (rd != '0) && (rd == rs) && use_rs;
  endfunction

  function automatic logic [1:0] fwd_sel(logic [REG_AW-1:0] rs, logic mw, logic [REG_AW-1:0] mrd,
                                         logic ww, logic [REG_AW-1:0] wrd);
    if (raw_hit(mw, mrd, rs, 1'b1)) return 2'b10;
    if (raw_hit(ww, wrd, rs, 1'b1)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] inc(logic [CNT_W-1:0] v, logic en);
    return v + {{(CNT_W-1){1'b0}}, en};
  endfunction

  assign hit_ex  = raw_hit(hz.ex_reg_write, hz.ex_rd, hz.id_rs1, hz.id_use_rs1) |
                   raw_hit(hz.ex_reg_write, hz.ex_rd, hz.id_rs2, hz.id_use_rs2);
  assign hit_mem = raw_hit(hz.mem_reg_write, hz.mem_rd, hz.id_rs1, hz.id_use_rs1) |
                   raw_hit(hz.mem_reg_write, hz.mem_rd, hz.id_rs2, hz.id_use_rs2);
  assign load_use = (FWD_EN != 0) ? (hit_ex & hz.ex_mem_read) : (hit_ex | hit_mem);

  // An op started this cycle already occupies EX, so the hold begins in the start cycle.
  assign mc_pend = ((state_q == MC_WAIT) | hz.ex_mc_start) & ~hz.ex_mc_done;
  assign br      = hz.branch_taken & ((BRANCH_STAGE == 3) | ~mc_pend);
  assign hold    = mc_pend & ~br;

  always_comb begin
    pc_en    = 1'b1;
    if_id_en = 1'b1;
    id_ex_en = 1'b1;
    if_fl    = 1'b0;
    id_fl    = 1'b0;
    ex_fl    = 1'b0;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    if (reset) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      if_fl    = 1'b1;
      id_fl    = 1'b1;
      ex_fl    = 1'b1;
    end else begin
      if (FWD_EN != 0) begin
        fwd_a = fwd_sel(hz.ex_rs1, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
        fwd_b = fwd_sel(hz.ex_rs2, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
      end
      if (br) begin
        if_fl = 1'b1;
        id_fl = (BRANCH_STAGE >= 2);
        ex_fl = (BRANCH_STAGE >= 3);
      end else if (hold) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
        ex_fl    = 1'b1;
      end else if (load_use) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_fl    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      cycle_q   <= '0;
      instret_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q <= hold ? MC_WAIT : RUN;
      if (hz.cnt_clear) begin
        cycle_q   <= '0;
        instret_q <= '0;
        stall_q   <= '0;
        flush_q   <= '0;
      end else begin
        cycle_q   <= inc(cycle_q, 1'b1);
        instret_q <= inc(instret_q, hz.wb_valid);
        stall_q   <= inc(stall_q, ~pc_en);
        flush_q   <= inc(flush_q, br);
      end
    end
  end

  assign hz.pc_enable    = pc_en;
  assign hz.if_id_enable = if_id_en;
  assign hz.id_ex_enable = id_ex_en;
  assign hz.if_flush     = if_fl;
  assign hz.id_flush     = id_fl;
  assign hz.ex_flush     = ex_fl;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.mc_busy      = (state_q == MC_WAIT) & ~reset;
  assign hz.cycle_cnt    = cycle_q;
  assign hz.instret_cnt  = instret_q;
  assign hz.stall_cnt    = stall_q;
  assign hz.flush_cnt    = flush_q;

endmodule
